// File: rtl/seg7_to_onehot_dec_if.sv
// rtl/seg7_to_onehot_dec_if.sv - decoded-digit result handshake between decoder and consumer
`timescale 1ns/1ps
interface seg7_to_onehot_dec_if;
  logic [9:0] dig_onehot;
  logic [3:0] dig_bcd;
  logic       dig_valid;
  logic       dig_ready;
  logic       dig_err;

  modport master (output dig_onehot, dig_bcd, dig_valid, dig_err, input dig_ready);
  modport slave  (input dig_onehot, dig_bcd, dig_valid, dig_err, output dig_ready);
endinterface

// File: rtl/seg7_to_onehot_dec.sv
// rtl/seg7_to_onehot_dec.sv - stability-qualified 7-segment to one-hot/BCD digit decoder
// Optional macro SEG_ALT_GLYPH_EN accepts the alternate 6/7/9 glyphs.
`timescale 1ns/1ps
module seg7_to_onehot_dec #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  input  logic                 seg_en,
  seg7_to_onehot_dec_if.master dig,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD, LOCK} state_t;

  localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

  state_t           state_q;
  logic [6:0]       cap_q;
  logic [7:0]       cnt_q;
  logic [9:0]       onehot_q;
  logic [3:0]       bcd_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic       blank;
  logic       dec_err;
  logic [3:0] dec_bcd;
  logic [9:0] dec_onehot;

  // A blank pattern is indistinguishable from "no sample" and never qualifies.
  assign blank = !seg_en || (seg_in == 7'h00);

  always_comb begin
    dec_err = 1'b0;
    dec_bcd = 4'hF;
    case (seg_in)
      7'h7E: dec_bcd = 4'd0;
      7'h30: dec_bcd = 4'd1;
      7'h6D: dec_bcd = 4'd2;
      7'h79: dec_bcd = 4'd3;
      7'h33: dec_bcd = 4'd4;
      7'h5B: dec_bcd = 4'd5;
      7'h5F: dec_bcd = 4'd6;
      7'h70: dec_bcd = 4'd7;
      7'h7F: dec_bcd = 4'd8;
      7'h7B: dec_bcd = 4'd9;
`ifdef SEG_ALT_GLYPH_EN
      7'h1F: dec_bcd = 4'd6;
      7'h72: dec_bcd = 4'd7;
      7'h73: dec_bcd = 4'd9;
`endif
      default: dec_err = 1'b1;
    endcase
    dec_onehot = dec_err ? 10'd0 : (10'd1 << dec_bcd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= 7'h00;
      cnt_q     <= 8'd0;
      onehot_q  <= 10'd0;
      bcd_q     <= 4'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, LOCK: begin
          if (blank) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else if (state_q == IDLE || seg_in != cap_q) begin
            // LOCK ignores a repeat of the held glyph so it is never re-issued.
            cap_q <= seg_in;
            cnt_q <= 8'd1;
            if (STABLE_CYCLES == 1) begin
              onehot_q <= dec_onehot;
              bcd_q    <= dec_bcd;
              err_q    <= dec_err;
              valid_q  <= 1'b1;
              state_q  <= HOLD;
            end else begin
              state_q <= QUAL;
            end
          end
        end
        QUAL: begin
          if (blank) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else if (seg_in != cap_q) begin
            cap_q <= seg_in;
            cnt_q <= 8'd1;
          end else if (cnt_q + 8'd1 == STABLE_LAST) begin
            cnt_q    <= cnt_q + 8'd1;
            onehot_q <= dec_onehot;
            bcd_q    <= dec_bcd;
            err_q    <= dec_err;
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (dig.dig_ready) begin
            valid_q <= 1'b0;
            state_q <= LOCK;
            if (err_q && err_cnt_q != ERR_MAX) begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dig.dig_onehot = onehot_q;
  assign dig.dig_bcd    = bcd_q;
  assign dig.dig_valid  = valid_q;
  assign dig.dig_err    = err_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: doc/seg7_to_onehot_dec.md
Name: seg7_to_onehot_dec

Overview:
Decoder on the opposite side of the one-hot-decimal to 7-segment encoder. It receives a sampled 7-segment pattern, for example from a display scan tap or an external panel. It qualifies the pattern for stability, decodes it back to a 10-bit one-hot digit plus a 4-bit BCD value, and presents the result on a valid/ready handshake. Malformed glyphs are flagged and counted.

Parameters:
STABLE_CYCLES, 4, consecutive identical sampled cycles required before a glyph is accepted (legal range 1..255)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment pattern, active-high, seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
seg_en  input  1  seg_in is valid this cycle
dig_onehot  output  10  one-hot digit, bit i set for decimal digit i
dig_bcd  output  4  binary digit value 0..9; 4'hF on error
dig_valid  output  1  decoded result available
dig_ready  input  1  consumer accepts result
dig_err  output  1  qualified pattern is not a legal digit glyph
err_cnt  output  CNT_W  count of accepted error results, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE. dig_onehot=0, dig_bcd=0, dig_valid=0, dig_err=0, err_cnt=0. Capture register and stability counter are cleared. Asserting reset in any state, including HOLD, drops dig_valid immediately.
- Blank: seg_in==7'h00 with seg_en=1 is treated exactly as seg_en=0. A blank is never qualified.
- Glyph table: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex). Any other non-blank pattern is an error glyph.
- FSM states are IDLE, QUAL, HOLD and LOCK.
- IDLE:
  - On a non-blank sample: capture seg_in into the capture register, set cnt=1, go to QUAL.
  - If STABLE_CYCLES==1: go directly to HOLD instead of QUAL.
- QUAL:
  - On a blank sample: go to IDLE and clear cnt.
  - If seg_in differs from the capture register: recapture and set cnt=1.
  - If seg_in matches: cnt++.
  - When cnt reaches STABLE_CYCLES: register the decode and go to HOLD.
- Decode latency: dig_valid rises on the clock edge that samples the STABLE_CYCLES-th identical sample. It is visible in the following cycle.
- HOLD:
  - dig_valid=1. dig_onehot, dig_bcd and dig_err are stable and seg_in is ignored.
  - Transfer occurs on a cycle with dig_valid && dig_ready; go to LOCK on the next edge, with dig_valid=0.
  - dig_ready may be held high permanently, giving a one-cycle valid pulse. Data outputs retain their last value after transfer.
- Error result: dig_err=1, dig_onehot=0, dig_bcd=4'hF. err_cnt increments on the transfer edge of an error result and saturates at 2^CNT_W-1.
- LOCK (no re-issue of a held glyph):
  - Same pattern as the capture register: stay in LOCK.
  - Blank: go to IDLE.
  - Different non-blank pattern: recapture, set cnt=1, go to QUAL (or HOLD if STABLE_CYCLES==1).
  - Repeating the same digit therefore requires at least one blank cycle in between.
- Simultaneous events:
  - In HOLD, a seg_in change during the transfer cycle is ignored. It is evaluated from LOCK in the next cycle.
  - In QUAL, a mismatch on the final counting cycle restarts qualification; no output is produced.

Optional Feature:
SEG_ALT_GLYPH_EN:
- Defined: additionally accept the alternate glyphs 6=1F (no top bar), 7=72 (with f), 9=73 (no bottom bar). These decode to digits 6, 7 and 9 with dig_err=0.
- Undefined: 1F, 72 and 73 are error glyphs.

Test Plan:
1. STABLE_CYCLES=4, dig_ready=1, seg_en=1, seg_in=6D held -> dig_valid asserted for exactly one cycle after the 4th sample; dig_onehot=10'b0000000100, dig_bcd=2, dig_err=0.
2. seg_in=30 for 2 cycles, then 79 for 4 cycles -> single result dig_bcd=3, onehot=10'b0000001000; no digit-1 result ever issued.
3. dig_ready=0, seg_in=7B held 4 cycles, then 30 for 10 cycles -> dig_bcd=9 remains valid and unchanged. After raising dig_ready, 9 transfers; then, since 30 has been held ≥4 cycles, a digit-1 result (onehot=10'b0000000010) is issued 4 cycles after LOCK.
4. seg_in=01 held 4 cycles, dig_ready=1 -> dig_err=1, onehot=0, dig_bcd=F, err_cnt=1. Repeat with CNT_W=2 for 5 error glyphs separated by blanks -> err_cnt saturates at 3.
5. seg_in=7F held 20 cycles -> exactly one result (8). Then one blank cycle and 7F for 4 cycles -> second result (8).
6. rst_n pulled low while in HOLD -> dig_valid, dig_err, onehot, bcd and err_cnt all 0 asynchronously. After release with 5F held 4 cycles -> digit 6 issued. With SEG_ALT_GLYPH_EN defined, 1F -> digit 6 with dig_err=0.
